// File: rtl/gbuff_stream_reader_pkg.sv
// Shared widths and state encoding for the global-buffer stream reader.
package gbuff_stream_reader_pkg;
    localparam int WORD_SIZE     = 32;
    localparam int GB_INDX_SIZE  = 8;
    localparam int GB_ADDR_COUNT = 1 << GB_INDX_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/gbuff_stream_reader_fifo.sv
// Small synchronous FIFO used as the skid buffer between the buffer port and the stream.
module gbuff_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_pop = pop & ~empty;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= next_ptr(wr_ptr);
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/gbuff_stream_reader.sv
// Burst read initiator: issues sequential single-word global-buffer reads and
// streams the returned words out through a credit-controlled skid FIFO.
module gbuff_stream_reader
    import gbuff_stream_reader_pkg::*;
#(
    parameter int WORD_SIZE  = gbuff_stream_reader_pkg::WORD_SIZE,
    parameter int INDX_SIZE  = GB_INDX_SIZE,
    parameter int LEN_SIZE   = 9,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [INDX_SIZE-1:0] base_index,
    input  logic [LEN_SIZE-1:0]  length,
    output logic                 busy,
    output logic                 done,
    output logic                 gb_wr_en,
    output logic [INDX_SIZE-1:0] gb_index,
    input  logic [WORD_SIZE-1:0] gb_data_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WORD_SIZE-1:0] m_data,
    output logic                 m_last
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t               state, state_nxt;
    logic [INDX_SIZE-1:0] addr;
    logic [LEN_SIZE-1:0]  issue_left;
    logic [LEN_SIZE-1:0]  pop_left;
    logic                 inflight;
    logic                 done_r;

    logic                 fifo_push, fifo_empty, fifo_full;
    logic [CNT_W-1:0]     fifo_count;
    logic [WORD_SIZE-1:0] fifo_dout;
    logic [CNT_W:0]       occupancy;
    logic                 pop, issue, accept, zero_cmd, last_pop;

    assign pop      = m_valid & m_ready;
    assign accept   = (state == IDLE) & start & (length != '0);
    assign zero_cmd = (state == IDLE) & start & (length == '0);
    assign last_pop = pop & (pop_left == LEN_SIZE'(1));

    // Credit check counts the word still in flight so a returning read always has a slot.
    assign occupancy = ({1'b0, fifo_count} + (CNT_W+1)'(inflight)) - (CNT_W+1)'(pop);
    assign issue     = (state == FETCH) & (issue_left != '0)
                     & (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign fifo_push = inflight & (~fifo_full | pop);

    assign busy     = (state != IDLE);
    assign done     = done_r;
    assign gb_wr_en = 1'b0;
    assign gb_index = addr;
    assign m_valid  = ~fifo_empty;
    assign m_data   = fifo_empty ? '0 : fifo_dout;
    assign m_last   = m_valid & (pop_left == LEN_SIZE'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = FETCH;
            FETCH:   if (issue && issue_left == LEN_SIZE'(1)) state_nxt = DRAIN;
            DRAIN:   if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            issue_left <= '0;
            pop_left   <= '0;
            inflight   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            done_r   <= zero_cmd | ((state == DRAIN) & last_pop);
            if (accept) begin
                addr       <= base_index;
                issue_left <= length;
                pop_left   <= length;
            end else begin
                if (issue) begin
                    addr       <= addr + 1'b1;
                    issue_left <= issue_left - 1'b1;
                end
                if (pop) pop_left <= pop_left - 1'b1;
            end
        end
    end

    gbuff_rd_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (pop),
        .din   (gb_data_out),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );
endmodule

// File: tb/tb_gbuff_stream_reader.sv
// Directed bench for gbuff_stream_reader with a registered global-buffer model.
module tb_gbuff_stream_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_index;
    logic [8:0]  length;
    logic        busy, done, gb_wr_en;
    logic [7:0]  gb_index;
    logic [31:0] gb_data_out;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] words[$];
    logic        lasts[$];
    int          hs_cyc[$];
    logic [7:0]  idx_log[$];
    int          stall_bad, early_done, wr_seen;
    bit          timed_out;
    int          ready_pat[6] = '{1, 0, 0, 1, 0, 1};

    always #5 clk = ~clk;

    gbuff_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_index(base_index), .length(length),
        .busy(busy), .done(done), .gb_wr_en(gb_wr_en), .gb_index(gb_index),
        .gb_data_out(gb_data_out), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    // Buffer model: gbuff[i] = 0xA000_0000 + i, one-cycle registered read.
    always @(posedge clk) gb_data_out <= 32'hA000_0000 + {24'd0, gb_index};

    always @(negedge clk) begin
        if (rst === 1'b0 && dut.inflight === 1'b1 && dut.fifo_full === 1'b1 && !(m_valid && m_ready)) begin
            errors++;
            $display("FAIL fifo_overflow: push into full FIFO at %0t", $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [7:0] b, input logic [8:0] n);
        start = 1'b1; base_index = b; length = n;
        tick();
        start = 1'b0;
    endtask

    // Runs the stream for up to budget cycles, recording handshakes until n words arrive.
    task automatic collect(input int n, input int mode, input int budget);
        int          cyc;
        bit          held;
        logic [31:0] held_d;
        words.delete(); lasts.delete(); hs_cyc.delete(); idx_log.delete();
        stall_bad = 0; early_done = 0; wr_seen = 0; timed_out = 0;
        cyc = 0; held = 0; held_d = '0;
        idx_log.push_back(gb_index);
        while (words.size() < n && cyc < budget) begin
            m_ready = (mode == 0) ? 1'b1 : (ready_pat[cyc % 6] != 0);
            if (held && !(m_valid === 1'b1 && m_data === held_d)) stall_bad++;
            if (m_valid && m_ready) begin
                words.push_back(m_data); lasts.push_back(m_last); hs_cyc.push_back(cyc);
                held = 0;
            end else if (m_valid) begin
                held = 1; held_d = m_data;
            end
            if (gb_wr_en !== 1'b0) wr_seen++;
            if (done === 1'b1) early_done++;
            if (gb_index !== idx_log[idx_log.size()-1]) idx_log.push_back(gb_index);
            tick();
            cyc++;
        end
        m_ready = 1'b1;
        if (words.size() < n) timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_index = '0; length = '0; m_ready = 1'b1;
        tick(); tick();
        checks++; if ({busy, done, m_valid, m_last, gb_wr_en} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, m_valid, m_last, gb_wr_en}); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
        checks++; if (gb_index !== 8'h00) begin errors++; $display("FAIL reset_gb_index: got %h expected 00", gb_index); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy %b m_valid %b expected 0 0", busy, m_valid); end
    endtask

    task automatic test_basic();
        issue_cmd(8'h10, 9'd4);
        checks++; if (busy !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL basic_lat0: busy %b m_valid %b expected 1 0", busy, m_valid); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1: m_valid %b expected 0", m_valid); end
        tick();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_lat2: m_valid %b expected 1", m_valid); end
        collect(4, 0, 50);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got %0d words expected 4", words.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (words[i] !== 32'hA000_0010 + i) begin errors++; $display("FAIL basic_word%0d: got %h expected %h", i, words[i], 32'hA000_0010 + i); end
            checks++; if (lasts[i] !== (i == 3)) begin errors++; $display("FAIL basic_last%0d: got %b expected %b", i, lasts[i], (i == 3)); end
        end
        checks++; if (hs_cyc[3] - hs_cyc[0] != 3) begin errors++; $display("FAIL basic_consecutive: span %0d expected 3", hs_cyc[3] - hs_cyc[0]); end
        checks++; if (early_done != 0 || wr_seen != 0) begin errors++; $display("FAIL basic_side: early_done %0d wr_seen %0d expected 0 0", early_done, wr_seen); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done: done %b busy %b expected 1 0", done, busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done %b expected 0", done); end
    endtask

    task automatic test_backpressure();
        issue_cmd(8'h20, 9'd6);
        collect(6, 1, 100);
        checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got %0d words expected 6", words.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (words[i] !== 32'hA000_0020 + i) begin errors++; $display("FAIL bp_word%0d: got %h expected %h", i, words[i], 32'hA000_0020 + i); end
        end
        checks++; if (lasts[5] !== 1'b1 || lasts[4] !== 1'b0) begin errors++; $display("FAIL bp_last: got %b%b expected 01", lasts[4], lasts[5]); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stall cycles expected 0", stall_bad); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: done %b expected 1", done); end
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] exp_idx[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        issue_cmd(8'hFE, 9'd4);
        collect(4, 0, 50);
        checks++; if (timed_out || idx_log.size() < 4) begin errors++; $display("FAIL wrap_timeout: words %0d idx %0d expected 4 4", words.size(), idx_log.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (idx_log[i] !== exp_idx[i]) begin errors++; $display("FAIL wrap_idx%0d: got %h expected %h", i, idx_log[i], exp_idx[i]); end
            checks++; if (words[i] !== 32'hA000_0000 + {24'd0, exp_idx[i]}) begin errors++; $display("FAIL wrap_word%0d: got %h expected %h", i, words[i], 32'hA000_0000 + {24'd0, exp_idx[i]}); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: done %b expected 1", done); end
        tick();
    endtask

    task automatic test_len0_busy();
        logic [7:0] idx0;
        idx0 = gb_index;
        issue_cmd(8'h55, 9'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0_done: done %b busy %b expected 1 0", done, busy); end
        checks++; if (gb_index !== idx0) begin errors++; $display("FAIL len0_idx: got %h expected %h", gb_index, idx0); end
        tick();
        checks++; if (done !== 1'b0 || m_valid !== 1'b0 || gb_index !== idx0) begin errors++; $display("FAIL len0_after: done %b m_valid %b idx %h expected 0 0 %h", done, m_valid, gb_index, idx0); end
        issue_cmd(8'h30, 9'd8);
        issue_cmd(8'h80, 9'd3);
        collect(8, 0, 60);
        checks++; if (timed_out) begin errors++; $display("FAIL busy_timeout: got %0d words expected 8", words.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (words[i] !== 32'hA000_0030 + i) begin errors++; $display("FAIL busy_word%0d: got %h expected %h", i, words[i], 32'hA000_0030 + i); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_done: done %b expected 1", done); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL busy_extra%0d: m_valid %b busy %b expected 0 0", i, m_valid, busy); end
        end
    endtask

    task automatic test_reset_mid();
        issue_cmd(8'h50, 9'd10);
        collect(3, 0, 50);
        checks++; if (timed_out || words[2] !== 32'hA000_0052) begin errors++; $display("FAIL rstmid_pre: got %h expected a0000052", words[2]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_after: m_valid %b busy %b done %b expected 0 0 0", m_valid, busy, done); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (done !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet%0d: done %b m_valid %b expected 0 0", i, done, m_valid); end
        end
        issue_cmd(8'h40, 9'd2);
        collect(2, 0, 50);
        checks++; if (words[0] !== 32'hA000_0040 || words[1] !== 32'hA000_0041) begin errors++; $display("FAIL rstmid_new: got %h %h expected a0000040 a0000041", words[0], words[1]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done: done %b expected 1", done); end
        tick();
    endtask

    task automatic test_back_to_back();
        issue_cmd(8'h60, 9'd2);
        collect(2, 0, 50);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1: done %b expected 1", done); end
        issue_cmd(8'h70, 9'd3);
        checks++; if (busy !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept: busy %b m_valid %b expected 1 0", busy, m_valid); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_lat1: m_valid %b expected 0", m_valid); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_data !== 32'hA000_0070) begin errors++; $display("FAIL b2b_lat2: m_valid %b data %h expected 1 a0000070", m_valid, m_data); end
        collect(3, 0, 50);
        for (int i = 0; i < 3; i++) begin
            checks++; if (words[i] !== 32'hA000_0070 + i) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, words[i], 32'hA000_0070 + i); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2: done %b expected 1", done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_len0_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
